// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state encoding and datapath select constants for the cache controller
package cache_pkg;

  // FSM state encoding; values are fixed so the state can be decoded by other logic
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2,
    RESUME    = 2'd3
  } cache_state_t;

  // cache write data source
  localparam logic SEL_CORE    = 1'b0;
  localparam logic SEL_MEM     = 1'b1;
  // memory address source
  localparam logic ADDR_REQ    = 1'b0;
  localparam logic ADDR_VICTIM = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter that holds at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // count events, sticking at the maximum value instead of wrapping
  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - miss sequencing FSM: stall, dirty writeback, line fill, perf counters
module cache_controller
  import cache_pkg::*;
#(
  parameter int MEM_LATENCY = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic             hit,
  input  logic             dirty_bit,
  input  logic             halted,
  output logic             stall,
  output logic             cache_we,
  output logic             mem_write_en,
  output logic             mem_in_select,
  output logic             victim_addr_sel,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  // wide enough to hold MEM_LATENCY-1; at least one bit even when MEM_LATENCY is 1
  localparam int CW = ($clog2(MEM_LATENCY + 1) < 1) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MEM_LATENCY - 1);

  cache_state_t    r_state;
  cache_state_t    w_next;
  logic [CW-1:0]   r_cnt;
  logic            w_req;
  logic            w_miss;
  logic            w_wb;
  logic            w_last;
  logic            w_mem_phase;

  assign w_req       = req_valid & ~halted;
  assign w_miss      = (r_state == IDLE) & w_req & ~hit;
  assign w_wb        = w_miss & dirty_bit;
  assign w_last      = (r_cnt == LAST_BEAT);
  assign w_mem_phase = (r_state == WRITEBACK) || (r_state == FILL);

  // state register; reset abandons any memory transaction in flight
  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // memory latency counter: runs only while a memory phase is active, clears on its last beat
  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_cnt <= '0;
    end else if (w_mem_phase && !w_last) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  // next-state and output decode; IDLE adds combinational hit/miss terms
  always_comb begin
    w_next          = r_state;
    stall           = 1'b0;
    cache_we        = 1'b0;
    mem_write_en    = 1'b0;
    mem_in_select   = SEL_CORE;
    victim_addr_sel = ADDR_REQ;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (hit) begin
            cache_we = req_write;
          end else begin
            stall  = 1'b1;
            w_next = dirty_bit ? WRITEBACK : FILL;
          end
        end
      end
      WRITEBACK: begin
        stall           = 1'b1;
        mem_write_en    = 1'b1;
        victim_addr_sel = ADDR_VICTIM;
        if (w_last) w_next = FILL;
      end
      FILL: begin
        stall         = 1'b1;
        mem_in_select = SEL_MEM;
        if (w_last) begin
          cache_we = 1'b1;
          w_next   = RESUME;
        end
      end
      RESUME: begin
        stall  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .inc   (w_miss),
    .count (miss_count)
  );

  sat_counter #(.W(CNT_W)) u_wb_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .inc   (w_wb),
    .count (wb_count)
  );

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Sequencing FSM between the core control path and the cache/memory datapath.
- Watches the core's load/store request and the cache hit/dirty status, stalls the core on a miss, and sequences dirty-line writeback and line fill against a fixed-latency main memory.
- Drives the cache write enable, memory write enable and the datapath mux selects.
- Keeps saturating miss/writeback performance counters.

Parameters:
- MEM_LATENCY, 4: cycles main memory needs per word access. Legal range is 1 or more.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_b  input  1  reset; synchronous, active-high (reset asserted when rst_b=1).
- req_valid  input  1  core issues a load or store this cycle.
- req_write  input  1  1=store, 0=load; valid with req_valid.
- hit  input  1  tag match for the current request address, from the memory datapath.
- dirty_bit  input  1  the indexed line is dirty, from the memory datapath.
- halted  input  1  core halted; no new requests are accepted.
- stall  output  1  freeze the core; the core's pc_we is driven as ~stall.
- cache_we  output  1  write the cache line (store hit or fill).
- mem_write_en  output  1  main-memory write strobe.
- mem_in_select  output  1  cache write data source: 0=core store data, 1=memory read data.
- victim_addr_sel  output  1  memory address source: 1=victim tag/index, 0=request address.
- miss_count  output  CNT_W  total misses, saturating.
- wb_count  output  CNT_W  total dirty writebacks, saturating.

Behaviour:
- States and encodings: IDLE=0, WRITEBACK=1, FILL=2, RESUME=3.
- Reset (rst_b=1 at the clock edge):
  - state=IDLE, latency counter=0, miss_count=0, wb_count=0.
  - All 1-bit outputs deasserted, including stall.
  - Reset wins over every other event, including mid-WRITEBACK. A partial memory write is abandoned with no retry.
- IDLE:
  - Request (req_valid & ~halted) with hit & ~req_write: stall=0 and no other output asserted. The load completes in the same cycle.
  - Request with hit & req_write: cache_we=1, mem_in_select=0, stall=0. Write-back policy, so memory is not touched and the datapath sets the dirty bit.
  - Request with ~hit: stall=1 combinationally in the same cycle and miss_count increments.
    - If dirty_bit=1: wb_count increments and the next state is WRITEBACK.
    - Otherwise the next state is FILL.
  - halted=1 masks req_valid; the FSM stays in IDLE.
- WRITEBACK:
  - Outputs: stall=1, mem_write_en=1, victim_addr_sel=1.
  - The counter increments every cycle.
  - When counter==MEM_LATENCY-1: counter clears and the next state is FILL.
- FILL:
  - Outputs: stall=1, victim_addr_sel=0, mem_in_select=1.
  - The counter increments every cycle.
  - When counter==MEM_LATENCY-1: cache_we=1 for that cycle only, counter clears, and the next state is RESUME.
- RESUME:
  - Outputs: stall=1 and nothing else, giving one cycle for the tag compare to settle.
  - Next state is IDLE unconditionally. In IDLE the retried access is then a hit, and a store then writes through the hit path.
- Stall cycles seen by the core for a miss request:
  - Clean miss: MEM_LATENCY+1 stalled cycles after the request cycle.
  - Dirty miss: 2*MEM_LATENCY+1 stalled cycles after the request cycle.
  - Total stalled cycles including the request cycle: MEM_LATENCY+2 (clean) and 2*MEM_LATENCY+2 (dirty).
- Inputs ignored outside IDLE:
  - req_valid, req_write, hit and dirty_bit are ignored in WRITEBACK, FILL and RESUME.
  - Deasserting req_valid mid-miss does not abort the transaction.
  - halted rising mid-miss does not abort; the miss completes and the FSM then parks in IDLE.
- MEM_LATENCY=1: WRITEBACK and FILL each last exactly one cycle. The cycle-0 check doubles as the last-cycle check.
- Counter width: $clog2(MEM_LATENCY+1), minimum 1 bit.
- miss_count and wb_count hold at all-ones on overflow (saturate, no wrap).
- Outputs are registered state decodes plus the IDLE combinational terms above. There are no latches.

Decomposition:
- Package cache_pkg holds:
  - the state enum cache_state_t (IDLE, WRITEBACK, FILL, RESUME);
  - the mux-select constants SEL_CORE=0, SEL_MEM=1, ADDR_REQ=0, ADDR_VICTIM=1.
- One sub-module sat_counter (parameter W; inputs clk, rst_b, inc; output count). It is instantiated twice, for miss_count and wb_count.
- The FSM and the latency counter stay in cache_controller.

Test Plan:
- Reset mid-WRITEBACK: with MEM_LATENCY=4, assert rst_b at the 2nd WRITEBACK cycle -> next cycle state=IDLE, stall=0, mem_write_en=0, counters=0.
- Load hit: req_valid=1, req_write=0, hit=1 -> stall=0, cache_we=0, mem_write_en=0 that cycle; miss_count stays 0.
- Store hit: req_valid=1, req_write=1, hit=1 -> cache_we=1, mem_in_select=0, stall=0 for exactly 1 cycle.
- Clean load miss:
  - Stimulus: MEM_LATENCY=4, hit=0, dirty_bit=0.
  - Response: stall high for 6 consecutive cycles (request cycle + 5); cache_we=1 only on the 4th FILL cycle with mem_in_select=1; mem_write_en never asserted; miss_count=1, wb_count=0.
- Dirty store miss:
  - Stimulus: MEM_LATENCY=4, hit=0, dirty_bit=1, req_valid dropped after 1 cycle.
  - Response: mem_write_en=1 with victim_addr_sel=1 for 4 cycles, then 4 FILL cycles, then RESUME; total stall 10 cycles; wb_count=1.
- Halt and saturation:
  - halted=1 with a missing request -> stays in IDLE with stall=0.
  - With CNT_W=2, 5 clean misses -> miss_count reads 3 and holds.
